// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback arbiter bus interface
//
// Groups the issue, requester and register-file write-port signals.
//   slave  : arbiter view (takes issue/requests, drives ready, we3/a3/wd3,
//            pending scoreboard and err_reissue)
//   master : surrounding pipeline / register file view
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            issue_valid;
    logic [AW-1:0]   issue_rd;

    logic            req0_valid;
    logic [AW-1:0]   req0_rd;
    logic [XLEN-1:0] req0_data;
    logic            req0_ready;

    logic            req1_valid;
    logic [AW-1:0]   req1_rd;
    logic [XLEN-1:0] req1_data;
    logic            req1_ready;

    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic [NREG-1:0] pending;
    logic            err_reissue;

    modport slave (
        input  issue_valid, issue_rd,
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        output we3, a3, wd3, pending, err_reissue
    );

    modport master (
        output issue_valid, issue_rd,
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        input  we3, a3, wd3, pending, err_reissue
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file writeback arbiter with pending scoreboard
//
// Shares the single register-file write port between the ALU (req0) and the
// load unit (req1). Grants are combinational; the write stage is registered,
// so a grant in cycle N appears on we3/a3/wd3 in cycle N+1. A scoreboard of
// outstanding writes lets the hazard unit stall dependent readers.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - regfile_wb_arbiter_if.slave (issue, req0/req1 handshakes,
//          we3/a3/wd3, pending, err_reissue)
//
// Build option: WB_FIXED_PRIO_EN - when defined the load unit (req1) always
// wins contention and the round-robin pointer is removed.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    logic            grant0;
    logic            grant1;
    logic            any_grant;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            we3_q,  we3_d;
    logic [AW-1:0]   a3_q,   a3_d;
    logic [XLEN-1:0] wd3_q,  wd3_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic            err_q,  err_d;

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            clr_same;

`ifdef WB_FIXED_PRIO_EN
    always_comb begin
        grant1 = bus.req1_valid;
        grant0 = bus.req0_valid & ~bus.req1_valid;
    end
`else
    // rr_ptr_q = 0 favours req0, 1 favours req1 on contention.
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        grant0   = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
        grant1   = bus.req1_valid & (~bus.req0_valid |  rr_ptr_q);
        rr_ptr_d = rr_ptr_q;
        // Point at the loser; if req0 won, the loser is req1 (pointer = 1).
        if (bus.req0_valid && bus.req1_valid) begin
            rr_ptr_d = grant0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign any_grant      = grant0 | grant1;

    always_comb begin
        sel_rd   = grant1 ? bus.req1_rd   : bus.req0_rd;
        sel_data = grant1 ? bus.req1_data : bus.req0_data;
    end

    // Write stage: x0 writes are accepted but suppressed at we3.
    always_comb begin
        we3_d = any_grant && (sel_rd != '0);
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (any_grant) begin
            a3_d  = sel_rd;
            wd3_d = sel_data;
        end
    end

    // Scoreboard. The clear uses the registered write so the bit drops on the
    // same edge the register file commits; set is applied after clear so a
    // new producer to the committing register stays tracked.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.issue_valid && bus.issue_rd != '0) begin
            set_mask[bus.issue_rd] = 1'b1;
        end
        if (we3_q) begin
            clr_mask[a3_q] = 1'b1;
        end
        clr_same  = we3_q && (a3_q == bus.issue_rd);
        pending_d = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
        err_d = err_q;
        if (bus.issue_valid && bus.issue_rd != '0
            && pending_q[bus.issue_rd] && !clr_same) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we3_q     <= 1'b0;
            a3_q      <= '0;
            wd3_q     <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            we3_q     <= we3_d;
            a3_q      <= a3_d;
            wd3_q     <= wd3_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign bus.we3         = we3_q;
    assign bus.a3          = a3_q;
    assign bus.wd3         = wd3_q;
    assign bus.pending     = pending_q;
    assign bus.err_reissue = err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard testbench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.XLEN(32), .NREG(32)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Every register-file write is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (bus.we3) begin
            if (exp_q.size() == 0) begin
                check("spurious_we3", {63'd0, bus.we3}, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("sb_a3",  {59'd0, bus.a3},  {59'd0, e.rd});
                check("sb_wd3", {32'd0, bus.wd3}, {32'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.req0_valid = 1'b0;  bus.req0_rd = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0;  bus.req1_rd = '0; bus.req1_data = '0;

        // Reset then idle
        cyc(); cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_we3",     {63'd0, bus.we3}, 64'd0);
            check("idle_pending", {32'd0, bus.pending}, 64'd0);
            check("idle_err",     {63'd0, bus.err_reissue}, 64'd0);
            check("idle_rdy",     {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
            cyc();
        end

        // Single request
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        @(negedge clk);
        cyc();
        bus.issue_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd5; bus.req0_data = 32'hDEADBEEF;
        push_wr(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("t2_ready0",  {63'd0, bus.req0_ready}, 64'd1);
        check("t2_ready1",  {63'd0, bus.req1_ready}, 64'd0);
        check("t2_pend_N",  {32'd0, bus.pending}, 64'h20);
        cyc();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("t2_we3",     {63'd0, bus.we3}, 64'd1);
        check("t2_pend_N1", {32'd0, bus.pending}, 64'h20);
        cyc();
        @(negedge clk);
        check("t2_pend_N2", {32'd0, bus.pending}, 64'h0);
        check("t2_we3_off", {63'd0, bus.we3}, 64'd0);

        // Contention from reset
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd3; bus.req0_data = 32'h11;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd4; bus.req1_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
`ifdef WB_FIXED_PRIO_EN
            push_wr(5'd4, 32'h22);
            @(negedge clk);
            check("t3_ready0", {63'd0, bus.req0_ready}, 64'd0);
            check("t3_ready1", {63'd0, bus.req1_ready}, 64'd1);
`else
            if (k % 2 == 0) push_wr(5'd3, 32'h11);
            else            push_wr(5'd4, 32'h22);
            @(negedge clk);
            check("t3_ready0", {63'd0, bus.req0_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
            check("t3_ready1", {63'd0, bus.req1_ready}, (k % 2 == 0) ? 64'd0 : 64'd1);
`endif
            cyc();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        check("t3_err", {63'd0, bus.err_reissue}, 64'd0);

        // x0 write and x0 issue
        cyc();
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd0; bus.req1_data = 32'hFFFFFFFF;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        @(negedge clk);
        check("t4_ready1", {63'd0, bus.req1_ready}, 64'd1);
        cyc();
        bus.req1_valid = 1'b0; bus.issue_valid = 1'b0;
        @(negedge clk);
        check("t4_we3",     {63'd0, bus.we3}, 64'd0);
        check("t4_pending", {32'd0, bus.pending}, 64'd0);

        // Set/clear collision on x7
        cyc();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        @(negedge clk);
        cyc();
        bus.issue_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd7; bus.req0_data = 32'h77;
        push_wr(5'd7, 32'h77);
        @(negedge clk);
        check("t5_pend7", {32'd0, bus.pending}, 64'h80);
        cyc();
        bus.req0_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        @(negedge clk);
        check("t5_commit_we3", {63'd0, bus.we3}, 64'd1);
        cyc();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        check("t5_pend7_kept", {32'd0, bus.pending}, 64'h80);
        check("t5_no_err",     {63'd0, bus.err_reissue}, 64'd0);
        cyc();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd7; bus.req0_data = 32'h78;
        push_wr(5'd7, 32'h78);
        @(negedge clk);
        cyc();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        check("t5_pend7_clr", {32'd0, bus.pending}, 64'h0);

        // Reissue to pending x9
        cyc();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        @(negedge clk);
        cyc();
        @(negedge clk);
        check("t5_err_pre", {63'd0, bus.err_reissue}, 64'd0);
        cyc();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        check("t5_err_set", {63'd0, bus.err_reissue}, 64'd1);
        check("t5_pend9",   {32'd0, bus.pending}, 64'h200);
        repeat (3) cyc();
        @(negedge clk);
        check("t5_err_sticky", {63'd0, bus.err_reissue}, 64'd1);

        // Reset mid-flight
        cyc();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
        @(negedge clk);
        cyc();
        bus.issue_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd6; bus.req0_data = 32'h66;
        rst = 1'b1;
        @(negedge clk);
        check("t6_ready0", {63'd0, bus.req0_ready}, 64'd1);
        cyc();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("t6_we3",     {63'd0, bus.we3}, 64'd0);
        check("t6_pending", {32'd0, bus.pending}, 64'd0);
        check("t6_err",     {63'd0, bus.err_reissue}, 64'd0);
        cyc();
        @(negedge clk);
        check("t6_we3_after", {63'd0, bus.we3}, 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
